data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Requester-side controller for the shared single-port data memory (registered read, 1-cycle q latency).
//  Arbitrates CORE_COUNT core load/store requests round-robin and drives address/data/wren.
//  Returns read data with a one-cycle ack pulse to the granted core.
//  Sits between the core array and the data memory instance; one transaction in flight at a time.
// PARAMETERS
//  CORE_COUNT     4   number of requesting cores (2..8)
//  data_width     12  memory word width
//  address_width  12  memory address width
// PORTS
//  clock       in   1                          system clock, rising edge
//  rstN        in   1                          asynchronous active-low reset
//  core_req    in   CORE_COUNT                 per-core request; held until core_ack
//  core_wr     in   CORE_COUNT                 per-core 1=store, 0=load
//  core_addr   in   CORE_COUNT*address_width   core i at [i*address_width +: address_width]
//  core_wdata  in   CORE_COUNT*data_width      core i at [i*data_width +: data_width]
//  core_ack    out  CORE_COUNT                 one-hot, 1-cycle completion pulse
//  core_rdata  out  data_width                 shared read-data bus; valid while core_ack!=0
//  mem_wren    out  1                          memory write enable
//  mem_address out  address_width              memory address
//  mem_data    out  data_width                 memory write data
//  mem_q       in   data_width                 memory registered read data
//  busy        out  1                          high in ISSUE and RESP
// BEHAVIOUR
//  - Reset (rstN low, async): state=IDLE; mem_wren=0, mem_address=0, mem_data=0, core_ack=0, busy=0.
//    rr pointer set so core 0 has highest priority first. An in-flight transaction is dropped, not acked.
//    A store whose ISSUE edge already passed may already be committed.
//  - FSM IDLE -> ISSUE -> RESP -> IDLE; all outputs registered except core_rdata = mem_q.
//  - IDLE: if any core_req, grant the first requester at or after (last_grant+1) mod CORE_COUNT.
//    On that edge: latch addr/wdata/wr into mem_address/mem_data/mem_wren, record grant, go to ISSUE.
//    No request: stay IDLE with mem_wren=0.
//  - ISSUE (cycle T+1): memory samples outputs; store commits at the end of this cycle.
//    Go to RESP; mem_wren cleared on this edge.
//  - RESP (cycle T+2): core_ack[grant]=1 for exactly this cycle; core_rdata=mem_q.
//    Go to IDLE; last_grant=grant.
//  - Latency: req sampled at T, ack during T+2; throughput 1 transaction per 3 cycles under continuous load.
//  - Store ack: core_rdata carries the pre-write word (memory read-before-write); cores ignore it.
//  - Core must drop or replace req on the edge ending its ack cycle; a still-high req is a new request.
//  - Request/inputs changing while not granted: ignored; only the value at the IDLE grant edge is used.
//  - Simultaneous requests: exactly one grant; no core waits more than CORE_COUNT-1 other grants.
//  - last_grant wraps CORE_COUNT-1 -> 0. Requests arriving during ISSUE/RESP wait for next IDLE.
//  - mem_address/mem_data hold their last values in IDLE; only mem_wren gates writes.
// CONFIGURATION
//  ARB_TXN_COUNT_EN defined:
//    - adds output txn_count [15:0] (reset 0).
//    - Increments on every RESP cycle; wraps 16'hFFFF -> 0.
//  ARB_TXN_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1 Reset: rstN=0 mid-ISSUE -> all outputs 0 immediately; no core_ack. After release: IDLE, busy=0.
//  2 Single store/load, core 2: store addr=12'h010 wdata=12'hABC; mem_wren=1 only in ISSUE.
//    Ack at T+2. Load addr=12'h010 -> core_ack=4'b0100 with core_rdata=12'hABC at T+2.
//  3 All 4 cores req continuously from reset -> ack order 0,1,2,3,0,1,...; each ack 3 cycles apart.
//  4 Core 1 only requesting after core 3 was last grant -> core 1 granted next IDLE cycle.
//    No stall on empty slots.
//  5 Store then load same addr by different cores (core0 wr 12'h7FF<-12'h123, core1 rd 12'h7FF).
//    -> core1 gets 12'h123. Core0 ack rdata = prior contents.
//  6 ARB_TXN_COUNT_EN: 70000 back-to-back transactions.
//    -> txn_count = 70000 mod 65536 = 4464. Reset clears it to 0.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin requester-side controller for a shared
// single-port data memory with a 1-cycle registered read.
// Each transaction runs IDLE -> ISSUE -> RESP, and only one is in flight at a time.
// Optional feature macro: ARB_TXN_COUNT_EN adds the txn_count[15:0] output,
// which counts completed (RESP) cycles and wraps at 16 bits.
module data_mem_arbiter #(
    parameter int CORE_COUNT    = 4,
    parameter int data_width    = 12,
    parameter int address_width = 12
) (
    input  logic                                clock,
    input  logic                                rstN,
    input  logic [CORE_COUNT-1:0]               core_req,
    input  logic [CORE_COUNT-1:0]               core_wr,
    input  logic [CORE_COUNT*address_width-1:0] core_addr,
    input  logic [CORE_COUNT*data_width-1:0]    core_wdata,
    output logic [CORE_COUNT-1:0]               core_ack,
    output logic [data_width-1:0]               core_rdata,
    output logic                                mem_wren,
    output logic [address_width-1:0]            mem_address,
    output logic [data_width-1:0]               mem_data,
    input  logic [data_width-1:0]               mem_q,
    output logic                                busy
`ifdef ARB_TXN_COUNT_EN
    ,
    output logic [15:0]                         txn_count
`endif
);

    localparam int unsigned N     = CORE_COUNT;
    localparam int          IDX_W = $clog2(CORE_COUNT);
    localparam logic [CORE_COUNT-1:0] ONE_HOT0 = CORE_COUNT'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                   state;
    logic [IDX_W-1:0]         grant;
    logic [IDX_W-1:0]         last_grant;

    logic                     found;
    logic [IDX_W-1:0]         next_grant;
    logic                     next_wr;
    logic [address_width-1:0] next_addr;
    logic [data_width-1:0]    next_wdata;

    // Read data comes straight from the memory's registered output.
    assign core_rdata = mem_q;

    // Round-robin pick: cores after last_grant first, then wrap to the cores at or below it.
    always_comb begin
        found      = 1'b0;
        next_grant = '0;
        next_wr    = 1'b0;
        next_addr  = '0;
        next_wdata = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && core_req[i] && (i > 32'(last_grant))) begin
                found      = 1'b1;
                next_grant = IDX_W'(i);
                next_wr    = core_wr[i];
                next_addr  = core_addr[i*address_width +: address_width];
                next_wdata = core_wdata[i*data_width +: data_width];
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && core_req[i] && (i <= 32'(last_grant))) begin
                found      = 1'b1;
                next_grant = IDX_W'(i);
                next_wr    = core_wr[i];
                next_addr  = core_addr[i*address_width +: address_width];
                next_wdata = core_wdata[i*data_width +: data_width];
            end
        end
    end

    // Transaction FSM with registered memory-side and core-side outputs.
    always_ff @(posedge clock or negedge rstN) begin
        if (!rstN) begin
            state       <= IDLE;
            grant       <= '0;
            last_grant  <= IDX_W'(CORE_COUNT - 1);
            mem_wren    <= 1'b0;
            mem_address <= '0;
            mem_data    <= '0;
            core_ack    <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    core_ack <= '0;
                    if (found) begin
                        mem_wren    <= next_wr;
                        mem_address <= next_addr;
                        mem_data    <= next_wdata;
                        grant       <= next_grant;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end else begin
                        mem_wren <= 1'b0;
                    end
                end
                ISSUE: begin
                    mem_wren <= 1'b0;
                    core_ack <= ONE_HOT0 << grant;
                    state    <= RESP;
                end
                RESP: begin
                    core_ack   <= '0;
                    busy       <= 1'b0;
                    last_grant <= grant;
                    state      <= IDLE;
                end
                default: begin
                    mem_wren <= 1'b0;
                    core_ack <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef ARB_TXN_COUNT_EN
    // Completed-transaction counter, stepped once per RESP cycle and free-wrapping.
    always_ff @(posedge clock or negedge rstN) begin
        if (!rstN) begin
            txn_count <= '0;
        end else if (state == RESP) begin
            txn_count <= txn_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: randomized core traffic against a transaction-level
// reference model. Expected acks are queued at grant time and checked by a monitor.
module tb_data_mem_arbiter;

    localparam int CC = 4;
    localparam int DW = 12;
    localparam int AW = 12;

    logic              clock = 1'b0;
    logic              rstN  = 1'b0;
    logic [CC-1:0]     core_req   = '0;
    logic [CC-1:0]     core_wr    = '0;
    logic [CC*AW-1:0]  core_addr  = '0;
    logic [CC*DW-1:0]  core_wdata = '0;
    logic [CC-1:0]     core_ack;
    logic [DW-1:0]     core_rdata;
    logic              mem_wren;
    logic [AW-1:0]     mem_address;
    logic [DW-1:0]     mem_data;
    logic [DW-1:0]     mem_q = '0;
    logic              busy;
`ifdef ARB_TXN_COUNT_EN
    logic [15:0]       txn_count;
`endif

    always #5 clock = ~clock;

    data_mem_arbiter #(
        .CORE_COUNT(CC),
        .data_width(DW),
        .address_width(AW)
    ) dut (
        .clock(clock),
        .rstN(rstN),
        .core_req(core_req),
        .core_wr(core_wr),
        .core_addr(core_addr),
        .core_wdata(core_wdata),
        .core_ack(core_ack),
        .core_rdata(core_rdata),
        .mem_wren(mem_wren),
        .mem_address(mem_address),
        .mem_data(mem_data),
        .mem_q(mem_q),
        .busy(busy)
`ifdef ARB_TXN_COUNT_EN
        ,
        .txn_count(txn_count)
`endif
    );

    // Environment: single-port memory, registered read, read-before-write.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        mem_q <= mem[mem_address];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: one transaction per 3 cycles, round-robin from core 0 after reset,
    // read returns the word stored before any write of the same transaction.
    typedef struct {
        int            core;
        logic [DW-1:0] rdata;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            m_last  = CC - 1;
    int            m_free  = 0;
    int            g_edge  = -10;
    int            st_edge = -10;
    int            m_txns  = 0;
    logic [AW-1:0] st_addr = '0;
    logic [DW-1:0] st_data = '0;

    always @(posedge clock or negedge rstN) begin : model
        int            w;
        exp_t          e;
        logic [AW-1:0] a;
        if (!rstN) begin
            m_last  = CC - 1;
            m_free  = 0;
            g_edge  = -10;
            st_edge = -10;
            m_txns  = 0;
            exp_q.delete();
        end else if (cyc >= m_free && core_req != '0) begin
            w = -1;
            for (int k = 1; k <= CC; k++)
                if (w < 0 && core_req[(m_last + k) % CC]) w = (m_last + k) % CC;
            a       = core_addr[w*AW +: AW];
            e.core  = w;
            e.rdata = ref_mem[a];
            e.due   = cyc + 2;
            exp_q.push_back(e);
            if (core_wr[w]) begin
                ref_mem[a] = core_wdata[w*DW +: DW];
                st_edge    = cyc;
                st_addr    = a;
                st_data    = core_wdata[w*DW +: DW];
            end
            g_edge = cyc;
            m_free = cyc + 3;
            m_last = w;
            m_txns++;
        end
    end

    logic [CC-1:0] ack_log[$];
    logic [DW-1:0] rd_log[$];

    // Monitor: compares every ack against the queue head, plus per-cycle busy/wren timing.
    always @(negedge clock) begin : monitor
        exp_t e;
        int   c;
        if (rstN) begin
            c = cyc;
            while (exp_q.size() > 0 && exp_q[0].due < c) begin
                check("ack_missing_at_cycle", 32'(c), 32'(exp_q[0].due));
                void'(exp_q.pop_front());
            end
            if (core_ack != '0) begin
                ack_log.push_back(core_ack);
                rd_log.push_back(core_rdata);
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'(core_ack), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_core", 32'(core_ack), 32'(1 << e.core));
                    check("ack_rdata", 32'(core_rdata), 32'(e.rdata));
                    check("ack_cycle", 32'(c), 32'(e.due));
                end
            end
            check("busy", 32'(busy), 32'(c == g_edge + 1 || c == g_edge + 2));
            check("mem_wren", 32'(mem_wren), 32'(c == st_edge + 1));
            if (c == st_edge + 1) begin
                check("store_addr", 32'(mem_address), 32'(st_addr));
                check("store_data", 32'(mem_data), 32'(st_data));
            end
        end
    end

    // One driver cycle: on the negedge, drop requests whose ack is showing unless holding.
    task automatic step(input bit hold);
        @(negedge clock);
        if (!hold) core_req = core_req & ~core_ack;
    endtask

    task automatic set_req(input int c, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_req[c]           = 1'b1;
        core_wr[c]            = wr;
        core_addr[c*AW +: AW] = a;
        core_wdata[c*DW +: DW] = d;
    endtask

    task automatic wait_quiet();
        int n;
        n = 0;
        do begin
            step(1'b0);
            n++;
        end while ((core_req != '0 || exp_q.size() != 0) && n < 300);
        if (n >= 300) check("quiet_timeout", 32'(exp_q.size()), 32'd0);
        repeat (2) step(1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_wren"}, 32'(mem_wren), 32'd0);
        check({tag, "_mem_address"}, 32'(mem_address), 32'd0);
        check({tag, "_mem_data"}, 32'(mem_data), 32'd0);
        check({tag, "_core_ack"}, 32'(core_ack), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef ARB_TXN_COUNT_EN
        check({tag, "_txn_count"}, 32'(txn_count), 32'd0);
`endif
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end

        // Reset values.
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        rstN = 1'b1;

        // All cores requesting continuously from reset: 0,1,2,3,0,...
        ack_log.delete();
        for (int c = 0; c < CC; c++) set_req(c, 1'b0, AW'(c + 1), '0);
        repeat (30) step(1'b1);
        core_req = '0;
        wait_quiet();
        check("t3_ack_count_ge8", 32'(ack_log.size() >= 8), 32'd1);
        if (ack_log.size() >= 8)
            for (int i = 0; i < 8; i++) check("t3_ack_order", 32'(ack_log[i]), 32'(1 << (i % 4)));

        // Core 2 store then load of the same word.
        set_req(2, 1'b1, 12'h010, 12'hABC);
        wait_quiet();
        set_req(2, 1'b0, 12'h010, 12'h000);
        wait_quiet();
        check("t2_load_ack", 32'(ack_log[$]), 32'h4);
        check("t2_load_data", 32'(rd_log[$]), 32'hABC);

        // Core 0 stores, core 1 loads the same address, both requesting together.
        set_req(0, 1'b1, 12'h7FF, 12'h123);
        set_req(1, 1'b0, 12'h7FF, 12'h000);
        wait_quiet();
        check("t5_store_old", 32'(rd_log[$-1]), 32'h000);
        check("t5_load_ack", 32'(ack_log[$]), 32'h2);
        check("t5_load_data", 32'(rd_log[$]), 32'h123);

        // Core 3 last granted, then only core 1 requests.
        set_req(3, 1'b0, 12'h005, 12'h000);
        wait_quiet();
        set_req(1, 1'b0, 12'h006, 12'h000);
        wait_quiet();
        check("t4_ack", 32'(ack_log[$]), 32'h2);

        // Randomized traffic; inputs of waiting cores also wander before their grant.
        for (int n = 0; n < 2000; n++) begin
            step(1'b0);
            for (int c = 0; c < CC; c++) begin
                if (!core_req[c] && ($urandom % 3 == 0))
                    set_req(c, 1'($urandom), AW'($urandom % 32), DW'($urandom));
                else if ($urandom % 4 == 0) begin
                    core_wr[c]             = 1'($urandom);
                    core_addr[c*AW +: AW]  = AW'($urandom % 32);
                    core_wdata[c*DW +: DW] = DW'($urandom);
                end
            end
        end
        wait_quiet();
`ifdef ARB_TXN_COUNT_EN
        check("txn_count", 32'(txn_count), 32'(m_txns % 65536));
`endif

        // Reset asserted in the middle of an ISSUE cycle.
        begin
            int n;
            n = 0;
            set_req(2, 1'b1, 12'hE00, 12'h555);
            while (mem_wren !== 1'b1 && n < 10) begin
                @(negedge clock);
                n++;
            end
            check("rst_reached_issue", 32'(mem_wren), 32'd1);
        end
        #2 rstN = 1'b0;
        core_req = '0;
        #1 check_reset_outputs("midrst");
        repeat (2) @(negedge clock);
        check_reset_outputs("midrst_hold");
        rstN = 1'b1;
        repeat (3) step(1'b0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_ack", 32'(core_ack), 32'd0);
        set_req(3, 1'b0, 12'hF01, 12'h000);
        set_req(0, 1'b0, 12'hF00, 12'h000);
        wait_quiet();
        check("post_rst_first_core0", 32'(ack_log[$-1]), 32'h1);
        check("post_rst_then_core3", 32'(ack_log[$]), 32'h8);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
